prog_seq: RTL

PROG_SEQ -- requirements
Module: prog_seq

---
 rtl/prog_seq.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/prog_seq.sv
// Program sequencer: loads a small program and feeds it word by word to a processor.
// Latency: one ISSUE cycle per instruction, plus one DATA cycle (mvi) or 1-4 WAIT cycles.
// Backpressure: Done from the processor paces WAIT/DATA; PAUSE holds until step or stop.
module prog_seq #(
    parameter int DATAWIDTH = 6,
    parameter int AW        = 4
) (
    input  logic                 Clock,
    input  logic                 Resetn,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 step_mode,
    input  logic                 step,
    input  logic                 wr_en,
    input  logic [AW-1:0]        wr_addr,
    input  logic [DATAWIDTH-1:0] wr_data,
    input  logic [AW-1:0]        last_addr,
    input  logic                 Done,
    output logic                 Run,
    output logic [DATAWIDTH-1:0] DIN,
    output logic                 busy,
    output logic                 halted,
    output logic                 err,
    output logic [AW-1:0]        pc,
    output logic [7:0]           icount
);

    localparam int         DEPTH  = 1 << AW;
    localparam logic [1:0] OP_MVI = 2'b01;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_DATA,
        S_WAIT,
        S_PAUSE,
        S_HALT,
        S_ERR
    } state_t;

    state_t               state;
    state_t               done_state;
    logic [DATAWIDTH-1:0] mem [DEPTH];
    logic [DATAWIDTH-1:0] cur_word;
    logic [AW-1:0]        iaddr;      // address of the opcode word in flight
    logic [1:0]           wait_cnt;   // WAIT cycles already spent without Done
    logic                 stop_lat;
    logic                 loadable;
    logic                 last_hit;

    assign loadable = (state == S_IDLE) || (state == S_HALT) || (state == S_ERR);
    assign cur_word = mem[pc];

    // Program RAM write port; only open while no program is running, never reset
    always_ff @(posedge Clock) begin
        if (wr_en && loadable) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Where to go once the current instruction completes
    always_comb begin
        // In DATA the pc already points at the data word, so it can also hit last_addr
        last_hit = (iaddr == last_addr) || ((state == S_DATA) && (pc == last_addr));
        if (last_hit) begin
            done_state = S_HALT;
        end else if (stop_lat || stop) begin
            done_state = S_IDLE;
        end else if (step_mode) begin
            done_state = S_PAUSE;
        end else begin
            done_state = S_ISSUE;
        end
    end

    // Sequencer state machine with program counter, instruction count and stop latch
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state    <= S_IDLE;
            pc       <= '0;
            icount   <= '0;
            iaddr    <= '0;
            wait_cnt <= '0;
            stop_lat <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_HALT, S_ERR: begin
                    // start together with stop is treated as no request
                    if (start && !stop) begin
                        state    <= S_ISSUE;
                        pc       <= '0;
                        icount   <= '0;
                        stop_lat <= 1'b0;
                    end
                end
                S_ISSUE: begin
                    if (stop) stop_lat <= 1'b1;
                    iaddr    <= pc;
                    pc       <= pc + 1'b1;
                    wait_cnt <= '0;
                    state    <= (cur_word[5:4] == OP_MVI) ? S_DATA : S_WAIT;
                end
                S_DATA: begin
                    if (stop) stop_lat <= 1'b1;
                    if (Done) begin
                        state <= done_state;
                        pc    <= pc + 1'b1;
                        if (icount != 8'hFF) icount <= icount + 8'd1;
                        if (done_state == S_IDLE) stop_lat <= 1'b0;
                    end else begin
                        state <= S_ERR;
                    end
                end
                S_WAIT: begin
                    if (stop) stop_lat <= 1'b1;
                    if (Done) begin
                        state <= done_state;
                        if (icount != 8'hFF) icount <= icount + 8'd1;
                        if (done_state == S_IDLE) stop_lat <= 1'b0;
                    end else if (wait_cnt == 2'd3) begin
                        state <= S_ERR;
                    end else begin
                        wait_cnt <= wait_cnt + 2'd1;
                    end
                end
                S_PAUSE: begin
                    if (stop) begin
                        state <= S_IDLE;
                    end else if (step) begin
                        state <= S_ISSUE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Output decode from the registered state; reset forces IDLE so these drop at once
    always_comb begin
        Run    = (state == S_ISSUE) || (state == S_DATA);
        DIN    = Run ? cur_word : '0;
        busy   = (state == S_ISSUE) || (state == S_DATA) || (state == S_WAIT);
        halted = (state == S_HALT);
        err    = (state == S_ERR);
    end

endmodule
